pkt_buf_alloc_ctrl: RTL



---
 rtl/pspin_cfg_pkg.sv | 23 ++
 rtl/pkt_buf_alloc_ctrl_lzc.sv | 23 ++
 rtl/pkt_buf_alloc_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pspin_cfg_pkg.sv
// Shared buffer-allocator configuration: default geometry, derived types and
// the slot-rounding helper used by the requester-side controller.
package pspin_cfg_pkg;

  localparam int unsigned DefBuffMemLength = 1024;
  localparam int unsigned DefMemSlotSize   = 64;
  localparam int unsigned DefNumTags       = 8;

  typedef logic [$clog2(DefBuffMemLength):0]   elem_size_t;
  typedef logic [$clog2(DefBuffMemLength)-1:0] elem_idx_t;
  typedef logic [$clog2(DefNumTags)-1:0]       tag_t;

  // Rounds up to whole slots; a zero-byte packet still occupies one slot.
  // Kept 32-bit wide so the oversize compare sees values past elem_size_t.
  function automatic int unsigned round_to_slot(input int unsigned size,
                                                input int unsigned slot);
    if (size == 0) begin
      return slot;
    end
    return (size + slot - 1) & ~(slot - 1);
  endfunction

endpackage

// File: rtl/pkt_buf_alloc_ctrl_lzc.sv
// Lowest-set-bit finder, used to pick the lowest free tag from the busy map.
module pkt_buf_alloc_ctrl_lzc #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0]         req_i,
  output logic [$clog2(Width)-1:0] idx_o,
  output logic                     empty_o
);

  localparam int unsigned IdxW = $clog2(Width);

  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

  assign empty_o = ~|req_i;

endmodule

// File: rtl/pkt_buf_alloc_ctrl.sv
// Requester-side packet-buffer allocation controller: rounds packet sizes to slots,
// requests buffers from the allocator, tags them, and frees them on completion.
module pkt_buf_alloc_ctrl
  import pspin_cfg_pkg::*;
#(
  parameter int unsigned BuffMemLength = DefBuffMemLength,
  parameter int unsigned MemSlotSize   = DefMemSlotSize,
  parameter int unsigned NumTags       = DefNumTags
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pkt_valid_i,
  output logic                       pkt_ready_o,
  input  elem_size_t                 pkt_size_i,
  output logic                       alloc_valid_o,
  input  logic                       alloc_ready_i,
  output elem_size_t                 alloc_size_o,
  input  elem_idx_t                  alloc_index_i,
  output logic                       buf_valid_o,
  input  logic                       buf_ready_i,
  output elem_idx_t                  buf_index_o,
  output elem_size_t                 buf_size_o,
  output tag_t                       buf_tag_o,
  input  logic                       done_valid_i,
  input  tag_t                       done_tag_i,
  output logic                       free_valid_o,
  output elem_idx_t                  free_index_o,
  output elem_size_t                 free_size_o,
  output logic                       drop_o,
  output logic                       err_o,
  output logic [$clog2(NumTags):0]   inflight_o
);

  localparam int unsigned TagW = $clog2(NumTags);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NumTags-1:0] busy_q, busy_d;
  logic [NumTags-1:0] free_mask;
  elem_idx_t          tbl_idx_q  [NumTags];
  elem_size_t         tbl_size_q [NumTags];
  elem_size_t         size_q;
  elem_idx_t          idx_q;
  tag_t               tag_q;
  logic               init_q;
  logic               drop_q;
  logic               err_q;
  logic               free_valid_q;
  elem_idx_t          free_idx_q;
  elem_size_t         free_size_q;

  tag_t               next_tag;
  logic               tags_empty;
  int unsigned        rounded;
  logic               oversize;
  logic               pkt_accept;
  logic               grant;
  logic               done_hit;

  assign free_mask = ~busy_q;

  pkt_buf_alloc_ctrl_lzc #(
    .Width (NumTags)
  ) u_lzc (
    .req_i   (free_mask),
    .idx_o   (next_tag),
    .empty_o (tags_empty)
  );

  assign rounded  = round_to_slot(32'(pkt_size_i), MemSlotSize);
  assign oversize = rounded > BuffMemLength;

  // init_q holds ready low until the first edge after reset release.
  assign pkt_ready_o   = init_q && (state_q == StIdle) && !tags_empty;
  assign pkt_accept    = pkt_ready_o && pkt_valid_i;
  assign grant         = (state_q == StReq) && alloc_ready_i;
  assign done_hit      = done_valid_i && busy_q[done_tag_i];

  assign alloc_valid_o = (state_q == StReq);
  assign alloc_size_o  = size_q;
  assign buf_valid_o   = (state_q == StOut);
  assign buf_index_o   = idx_q;
  assign buf_size_o    = size_q;
  assign buf_tag_o     = tag_q;
  assign free_valid_o  = free_valid_q;
  assign free_index_o  = free_idx_q;
  assign free_size_o   = free_size_q;
  assign drop_o        = drop_q;
  assign err_o         = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pkt_accept && !oversize) state_d = StReq;
      StReq:   if (alloc_ready_i) state_d = StOut;
      StOut:   if (buf_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant and done never target the same tag, so set and clear commute.
  always_comb begin
    busy_d = busy_q;
    if (grant) begin
      busy_d[tag_q] = 1'b1;
    end
    if (done_hit) begin
      busy_d[done_tag_i] = 1'b0;
    end
  end

  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < NumTags; i++) begin
      inflight_o = inflight_o + (TagW + 1)'(busy_q[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      busy_q       <= '0;
      size_q       <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      init_q       <= 1'b0;
      drop_q       <= 1'b0;
      err_q        <= 1'b0;
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
      free_size_q  <= '0;
      for (int i = 0; i < NumTags; i++) begin
        tbl_idx_q[i]  <= '0;
        tbl_size_q[i] <= '0;
      end
    end else begin
      init_q       <= 1'b1;
      state_q      <= state_d;
      busy_q       <= busy_d;
      drop_q       <= pkt_accept && oversize;
      err_q        <= done_valid_i && !busy_q[done_tag_i];
      free_valid_q <= done_hit;
      if (pkt_accept && !oversize) begin
        size_q <= elem_size_t'(rounded);
        tag_q  <= next_tag;
      end
      if (grant) begin
        idx_q             <= alloc_index_i;
        tbl_idx_q[tag_q]  <= alloc_index_i;
        tbl_size_q[tag_q] <= size_q;
      end
      if (done_hit) begin
        free_idx_q  <= tbl_idx_q[done_tag_i];
        free_size_q <= tbl_size_q[done_tag_i];
      end
    end
  end

endmodule
